// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: bubble word,
// slot occupancy encoding and the payload field map used to pack/unpack
// stage payloads at each instantiation.
package pipe_pkg;

    // Control word carried by a bubble; bit 31 marks "no instruction".
    localparam logic [31:0] PIPE_NOP = 32'h8000_0000;

    // Occupancy of a stage register: nothing, main entry only, main + skid.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_MAIN  = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_state_e;

    // Field widths. The control word sits at bit 0 so that the low word of
    // a bubble payload reads as PIPE_NOP.
    localparam int unsigned SIG_W    = 32;
    localparam int unsigned IR_W     = 32;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned DST_W    = 5;
    localparam int unsigned RPOS_W   = 5;
    localparam int unsigned WORD_W   = 32;

    // Field offsets within the superset payload.
    localparam int unsigned SIG_OFF    = 0;
    localparam int unsigned IR_OFF     = SIG_OFF + SIG_W;
    localparam int unsigned PC_OFF     = IR_OFF + IR_W;
    localparam int unsigned DST_OFF    = PC_OFF + PC_W;
    localparam int unsigned R1_POS_OFF = DST_OFF + DST_W;
    localparam int unsigned R2_POS_OFF = R1_POS_OFF + RPOS_W;
    localparam int unsigned R1_OFF     = R2_POS_OFF + RPOS_W;
    localparam int unsigned R2_OFF     = R1_OFF + WORD_W;
    localparam int unsigned ALU_R_OFF  = R2_OFF + WORD_W;
    localparam int unsigned EXT_OFF    = ALU_R_OFF + WORD_W;
    localparam int unsigned V0_OFF     = EXT_OFF + WORD_W;
    localparam int unsigned A0_OFF     = V0_OFF + WORD_W;
    localparam int unsigned FULL_W     = A0_OFF + WORD_W;

    // Per-stage payload widths (IF/ID carries control, IR and PC only).
    localparam int unsigned IF_ID_W  = PC_OFF + PC_W;
    localparam int unsigned ID_EX_W  = FULL_W;
    localparam int unsigned EX_MEM_W = FULL_W;
    localparam int unsigned MEM_WB_W = FULL_W;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for stall/flush performance statistics.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment on request, sticking at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with ready/valid handshake, hazard hold, flush,
// optional skid entry (registered in_ready) and stall/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = 160,
    parameter int unsigned       SKID     = 0,
    parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(PIPE_NOP),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              main_vld;
    logic              skid_vld;
    logic              accept;
    logic              consume;
    logic              stall_inc;
    logic              flush_inc;

    assign main_vld = (state_q != SLOT_EMPTY);
    assign skid_vld = (state_q == SLOT_FULL);

    // Upstream readiness: combinational pass-through without skid, or a
    // function of registered occupancy and hold only when the skid exists.
    always_comb begin
        if (SKID != 0) begin
            in_ready = !hold && !skid_vld;
        end else begin
            in_ready = !hold && !flush && (!main_vld || out_ready);
        end
    end

    assign accept  = in_valid && in_ready;
    assign consume = main_vld && out_ready;

    // Next occupancy and entry contents; flush discards everything,
    // including a word whose handshake completes in the same cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = SLOT_EMPTY;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = SLOT_MAIN;
                    end
                end
                SLOT_MAIN: begin
                    if (consume && accept) begin
                        main_d = in_data;
                    end else if (consume) begin
                        state_d = SLOT_EMPTY;
                    end else if (accept) begin
                        // Main is held downstream; park the word in skid.
                        skid_d  = in_data;
                        state_d = SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = SLOT_MAIN;
                    end
                end
                default: state_d = SLOT_EMPTY;
            endcase
        end
    end

    // Occupancy register; reset drops any in-flight entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers; contents are only meaningful when occupancy says so.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign out_valid = main_vld;
    assign out_data  = main_vld ? main_q : NOP_DATA;

    assign stall_inc = in_valid && !in_ready && !flush;
    assign flush_inc = flush && (main_vld || in_valid);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: dut0 is a 32-bit single-entry stage with 4-bit counters,
// dut1 is a 40-bit skid stage with 16-bit counters.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP0 = 32'h8000_0000;
    localparam logic [39:0] NOP1 = 40'h00_8000_0000;

    logic        clk;
    logic        rst_n;

    logic        iv0, ir0, h0, f0, ov0, or0;
    logic [31:0] id0, od0;
    logic [3:0]  sc0, fc0;

    logic        iv1, ir1, h1, f1, ov1, or1;
    logic [39:0] id1, od1;
    logic [15:0] sc1, fc1;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(4)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv0),
        .in_ready  (ir0),
        .in_data   (id0),
        .hold      (h0),
        .flush     (f0),
        .out_valid (ov0),
        .out_ready (or0),
        .out_data  (od0),
        .stall_cnt (sc0),
        .flush_cnt (fc0)
    );

    pipe_stage_reg #(.DATA_W(40), .SKID(1), .CNT_W(16)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .in_data   (id1),
        .hold      (h1),
        .flush     (f1),
        .out_valid (ov1),
        .out_ready (or1),
        .out_data  (od1),
        .stall_cnt (sc1),
        .flush_cnt (fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        iv0 = 0; id0 = '0; h0 = 0; f0 = 0; or0 = 0;
        iv1 = 0; id1 = '0; h1 = 0; f1 = 0; or1 = 0;
        #2;
        chk("rst_ov0", ov0, 0);
        chk("rst_od0", od0, NOP0);
        chk("rst_sc0", sc0, 0);
        chk("rst_fc0", fc0, 0);
        chk("rst_ir0", ir0, 1);
        chk("rst_ov1", ov1, 0);
        chk("rst_od1", od1, NOP1);
        chk("rst_ir1", ir1, 1);
        tick();
        rst_n = 1'b1;

        // Stream 1..8 through dut0 with downstream always ready.
        or0 = 1; iv0 = 1; id0 = 32'd1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("stream_ov", ov0, 1);
            chk("stream_od", od0, i);
            if (i < 8) id0 = i + 1;
            else iv0 = 0;
        end
        tick();
        chk("stream_end_ov", ov0, 0);
        chk("stream_end_od", od0, NOP0);
        chk("stream_sc", sc0, 0);

        // Load-use hold on dut0: one bubble, one stall.
        iv0 = 1; id0 = 32'hA1;
        tick();
        chk("hold_pre_od", od0, 32'hA1);
        h0 = 1; id0 = 32'hA2;
        #1;
        chk("hold_ir", ir0, 0);
        tick();
        chk("hold_bubble_ov", ov0, 0);
        chk("hold_bubble_od", od0, NOP0);
        chk("hold_sc", sc0, 1);
        h0 = 0;
        tick();
        chk("hold_after_od", od0, 32'hA2);

        // Flush dut0 while main valid and a word is offered.
        or0 = 0; f0 = 1; id0 = 32'hA3;
        #1;
        chk("flush0_ir", ir0, 0);
        tick();
        chk("flush0_ov", ov0, 0);
        chk("flush0_od", od0, NOP0);
        chk("flush0_fc", fc0, 1);
        chk("flush0_sc", sc0, 1);
        f0 = 0; iv0 = 0;
        tick();
        chk("flush0_gone", ov0, 0);

        // Saturation: 20 more stall cycles on a 4-bit counter.
        h0 = 1; iv0 = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_mid", sc0, 11);
        for (int i = 0; i < 10; i++) tick();
        chk("sat_end", sc0, 15);
        h0 = 0; iv0 = 0;

        // Backpressure on dut1: A to main, B to skid, C held upstream.
        or1 = 0; iv1 = 1; id1 = 40'hAA_0000_000A;
        tick();
        chk("bp_a_od", od1, 40'hAA_0000_000A);
        chk("bp_a_ir", ir1, 1);
        id1 = 40'hBB_0000_000B;
        tick();
        chk("bp_full_ir", ir1, 0);
        chk("bp_full_od", od1, 40'hAA_0000_000A);
        id1 = 40'hCC_0000_000C;
        tick();
        chk("bp_c_held_od", od1, 40'hAA_0000_000A);
        chk("bp_sc1", sc1, 1);
        or1 = 1;
        #1;
        chk("bp_ir_reg", ir1, 0);
        tick();
        chk("bp_out_b", od1, 40'hBB_0000_000B);
        chk("bp_sc2", sc1, 2);
        chk("bp_ir_back", ir1, 1);
        tick();
        chk("bp_out_c", od1, 40'hCC_0000_000C);
        iv1 = 0;
        tick();
        chk("bp_drained_ov", ov1, 0);
        chk("bp_drained_od", od1, NOP1);
        chk("bp_sc_final", sc1, 2);

        // Throughput on dut1: one word per cycle with downstream ready.
        iv1 = 1; id1 = 40'hE1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("thru_od", od1, 40'hE0 + i);
            if (i < 3) id1 = 40'hE1 + i;
            else iv1 = 0;
        end
        tick();
        chk("thru_end_ov", ov1, 0);

        // Flush dut1 while FULL with an incoming word.
        or1 = 0; iv1 = 1; id1 = 40'hD1;
        tick();
        id1 = 40'hD2;
        tick();
        f1 = 1; id1 = 40'hD3;
        tick();
        chk("flush1_ov", ov1, 0);
        chk("flush1_od", od1, NOP1);
        chk("flush1_fc", fc1, 1);
        chk("flush1_sc", sc1, 2);
        f1 = 0; iv1 = 0;
        tick();
        chk("flush1_gone", ov1, 0);

        // Same with hold and flush together.
        iv1 = 1; id1 = 40'hD4;
        tick();
        id1 = 40'hD5;
        tick();
        chk("hf_full_ir", ir1, 0);
        h1 = 1; f1 = 1; id1 = 40'hD6;
        tick();
        chk("hf_ov", ov1, 0);
        chk("hf_od", od1, NOP1);
        chk("hf_fc", fc1, 2);
        h1 = 0; f1 = 0; iv1 = 0;
        tick();
        chk("hf_gone", ov1, 0);

        // Flush with main only: handshake completes but the word is dropped.
        iv1 = 1; id1 = 40'hD7;
        tick();
        f1 = 1; id1 = 40'hD8;
        #1;
        chk("fm_ir", ir1, 1);
        tick();
        chk("fm_ov", ov1, 0);
        chk("fm_fc", fc1, 3);
        f1 = 0; iv1 = 0;
        tick();
        chk("fm_gone", ov1, 0);

        // Asynchronous reset between edges with dut1 holding a word.
        iv1 = 1; id1 = 40'hF1;
        tick();
        chk("ar_pre_ov", ov1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ov1", ov1, 0);
        chk("ar_od1", od1, NOP1);
        chk("ar_sc1", sc1, 0);
        chk("ar_fc1", fc1, 0);
        chk("ar_sc0", sc0, 0);
        chk("ar_fc0", fc0, 0);
        id1 = 40'hF2; or1 = 1;
        #1;
        rst_n = 1'b1;
        tick();
        chk("ar_first_acc", od1, 40'hF2);
        iv1 = 0;
        tick();
        chk("ar_end_ov", ov1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
